// File: rtl/perf_report_pkg.sv
// Shared constants and state types for the performance-counter UART reporter.
package perf_report_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 12;
    localparam int         IDX_W       = $clog2(FRAME_BYTES);

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SEND,
        FR_DRAIN
    } framer_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. Accepts a new byte while idle or in the
// last cycle of its stop bit, so consecutive bytes go out with no idle gap.
module uart_tx_byte
    import perf_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       idle
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    ser_state_t        r_state;
    ser_state_t        w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              w_bitEnd;
    logic              w_accept;

    assign w_bitEnd = (r_cnt == LAST_CNT);
    assign ready    = (r_state == SER_IDLE) || ((r_state == SER_STOP) && w_bitEnd);
    assign w_accept = valid && ready;
    assign idle     = (r_state == SER_IDLE);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SER_IDLE:  if (w_accept) w_nextState = SER_START;
            SER_START: if (w_bitEnd) w_nextState = SER_DATA;
            SER_DATA:  if (w_bitEnd && (r_bit == 3'd7)) w_nextState = SER_STOP;
            SER_STOP:  if (w_bitEnd) w_nextState = w_accept ? SER_START : SER_IDLE;
            default:   w_nextState = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= SER_IDLE;
        else     r_state <= w_nextState;
    end

    // Baud counter restarts on every accepted byte and at each bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= data;
        end else if (r_state != SER_IDLE) begin
            if (w_bitEnd) begin
                r_cnt <= '0;
                if (r_state == SER_DATA) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            SER_START: tx = 1'b0;
            SER_DATA:  tx = r_shift[0];
            default:   tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/perf_report_tx.sv
// Snapshots the four core performance counters on start and ships them as a
// fixed 12-byte UART frame: sync, counters big-endian, XOR checksum.
module perf_report_tx
    import perf_report_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [27:0] clk_cycles,
    input  logic [12:0] retired_instructions,
    input  logic [12:0] predictions_made,
    input  logic [12:0] correct_predictions,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("perf_report_tx: CLK_FREQ_HZ/BAUD must be at least 2");
        end
    endgenerate

    framer_state_t     r_state;
    framer_state_t     w_nextState;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_csum;
    logic [27:0]       r_cycles;
    logic [12:0]       r_retired;
    logic [12:0]       r_preds;
    logic [12:0]       r_correct;
    logic              r_done;
    logic [31:0]       w_cyc32;
    logic [15:0]       w_ret16;
    logic [15:0]       w_pred16;
    logic [15:0]       w_corr16;
    logic [7:0]        w_byte;
    logic              w_valid;
    logic              w_ready;
    logic              w_idle;
    logic              w_accept;
    logic              w_drainEnd;

    assign w_cyc32  = {4'h0, r_cycles};
    assign w_ret16  = {3'b000, r_retired};
    assign w_pred16 = {3'b000, r_preds};
    assign w_corr16 = {3'b000, r_correct};

    always_comb begin
        w_byte = SYNC_BYTE;
        case (r_idx)
            4'd1:    w_byte = w_cyc32[31:24];
            4'd2:    w_byte = w_cyc32[23:16];
            4'd3:    w_byte = w_cyc32[15:8];
            4'd4:    w_byte = w_cyc32[7:0];
            4'd5:    w_byte = w_ret16[15:8];
            4'd6:    w_byte = w_ret16[7:0];
            4'd7:    w_byte = w_pred16[15:8];
            4'd8:    w_byte = w_pred16[7:0];
            4'd9:    w_byte = w_corr16[15:8];
            4'd10:   w_byte = w_corr16[7:0];
            4'd11:   w_byte = r_csum;
            default: w_byte = SYNC_BYTE;
        endcase
    end

    assign w_accept   = w_valid && w_ready;
    // Ready while not idle can only mean the final cycle of a stop bit.
    assign w_drainEnd = (r_state == FR_DRAIN) && w_ready && !w_idle;

    always_comb begin
        w_nextState = r_state;
        w_valid     = 1'b0;
        case (r_state)
            FR_IDLE: begin
                w_valid = start;
                if (w_accept) w_nextState = FR_SEND;
            end
            FR_SEND: begin
                w_valid = 1'b1;
                if (w_accept && (r_idx == LAST_IDX)) w_nextState = FR_DRAIN;
            end
            FR_DRAIN: begin
                if (w_drainEnd) w_nextState = FR_IDLE;
            end
            default: w_nextState = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FR_IDLE;
        else     r_state <= w_nextState;
    end

    // The sync byte leaves in the same edge the counters are captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_csum    <= 8'h00;
            r_cycles  <= 28'd0;
            r_retired <= 13'd0;
            r_preds   <= 13'd0;
            r_correct <= 13'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_drainEnd;
            if ((r_state == FR_IDLE) && w_accept) begin
                r_cycles  <= clk_cycles;
                r_retired <= retired_instructions;
                r_preds   <= predictions_made;
                r_correct <= correct_predictions;
                r_csum    <= 8'h00;
                r_idx     <= IDX_W'(1);
            end else if ((r_state == FR_SEND) && w_accept) begin
                if (r_idx == LAST_IDX) begin
                    r_idx <= '0;
                end else begin
                    r_idx  <= r_idx + 1'b1;
                    r_csum <= r_csum ^ w_byte;
                end
            end
        end
    end

    assign busy = (r_state != FR_IDLE);
    assign done = r_done;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .data (w_byte),
        .valid(w_valid),
        .ready(w_ready),
        .tx   (tx),
        .idle (w_idle)
    );

endmodule
